// File: rtl/aes128_encrypt_ctrl_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers.
// The S-box is computed as the field inverse followed by the affine map.
package aes_pkg;
    localparam int         NUM_ROUNDS = 10;
    localparam int         BLOCK_W    = 128;
    localparam logic [3:0] RC_LAST    = 4'd10;

    typedef enum logic [1:0] {IDLE, RUN, LAST} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // inverse is b^254, built from the squares b^2 .. b^128
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 16; i++)
            if (4'(i) < rc) r = xtime(r);
        return r;
    endfunction
endpackage

// File: rtl/aes128_encrypt_ctrl_if.sv
// Start/done handshake and data bus between a requester and the AES controller.
interface aes128_encrypt_ctrl_if;
    import aes_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] plaintext;
    logic [BLOCK_W-1:0] key;
    logic               busy;
    logic               done;
    logic [BLOCK_W-1:0] ciphertext;

    modport master (output start, plaintext, key, input busy, done, ciphertext);
    modport slave  (input start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/aes128_encrypt_ctrl_round.sv
// AES round building blocks: key expansion step, SubBytes, ShiftRows, MixColumns,
// plus the full round (rounds 1-9) and the final round without MixColumns.
module key_generation
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);
    logic [31:0] w0, w1, w2, w3, rot, temp;

    assign {w0, w1, w2, w3} = key_in;
    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon(rc), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign key_out[127:96] = w0 ^ temp;
    assign key_out[95:64]  = w1 ^ key_out[127:96];
    assign key_out[63:32]  = w2 ^ key_out[95:64];
    assign key_out[31:0]   = w3 ^ key_out[63:32];
endmodule

module subbytes
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
endmodule

// byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4
module shiftrow (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

module mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = din[127-32*c -: 32];
        assign dout[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
endmodule

module round (
    input  logic [3:0]   rc,
    input  logic [127:0] data,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [127:0] rndout
);
    logic [127:0] sb, sr, mc;

    key_generation u_kg (.rc(rc), .key_in(key_in), .key_out(key_out));
    subbytes       u_sb (.din(data), .dout(sb));
    shiftrow       u_sr (.din(sb), .dout(sr));
    mixcolumns     u_mc (.din(sr), .dout(mc));

    assign rndout = mc ^ key_out;
endmodule

module final_round (
    input  logic [3:0]   rc,
    input  logic [127:0] data,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [127:0] rndout
);
    logic [127:0] sb, sr;

    key_generation u_kg (.rc(rc), .key_in(key_in), .key_out(key_out));
    subbytes       u_sb (.din(data), .dout(sb));
    shiftrow       u_sr (.din(sb), .dout(sr));

    assign rndout = sr ^ key_out;
endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one round per cycle, ten cycles per block.
// state | meaning
// IDLE  | waiting for start; ciphertext holds the last result
// RUN   | rounds 1..NUM_ROUNDS-1 through the shared round datapath
// LAST  | final round, registers ciphertext and pulses done
module aes128_encrypt_ctrl #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst,
    aes128_encrypt_ctrl_if.slave bus
);
    import aes_pkg::*;

    localparam logic [3:0] RC_PENULT = 4'(NUM_ROUNDS - 1);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_reg, state_d, key_reg, key_d, ct_q, ct_d;
    logic [3:0]   rc_reg, rc_d;
    logic         done_q, done_d;
    logic [127:0] rnd_key, rnd_out, fin_key, fin_out;

    round u_round (
        .rc(rc_reg), .data(state_reg), .key_in(key_reg), .key_out(rnd_key), .rndout(rnd_out)
    );

    final_round u_final (
        .rc(rc_reg), .data(state_reg), .key_in(key_reg), .key_out(fin_key), .rndout(fin_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rc_reg    <= '0;
            ct_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_reg <= state_d;
            key_reg   <= key_d;
            rc_reg    <= rc_d;
            ct_q      <= ct_d;
            done_q    <= done_d;
        end
    end

    // out-of-range rc values abandon the block and fall back to IDLE
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_reg;
        key_d   = key_reg;
        rc_d    = rc_reg;
        ct_d    = ct_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.plaintext ^ bus.key;
                    key_d   = bus.key;
                    rc_d    = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (rc_reg == 4'd0 || rc_reg > RC_PENULT) begin
                    fsm_d = IDLE;
                end else begin
                    state_d = rnd_out;
                    key_d   = rnd_key;
                    rc_d    = rc_reg + 4'd1;
                    if (rc_reg == RC_PENULT) fsm_d = LAST;
                end
            end
            LAST: begin
                fsm_d = IDLE;
                if (rc_reg == RC_LAST) begin
                    ct_d   = fin_out;
                    key_d  = fin_key;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.busy       = (fsm_q != IDLE);
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;
endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Scenario bench for aes128_encrypt_ctrl using FIPS-197 known-answer vectors.
module tb_aes128_encrypt_ctrl;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    logic [127:0] sb[$];

    always #5 clk = ~clk;

    aes128_encrypt_ctrl_if bus();

    aes128_encrypt_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one start cycle; the expected result is queued only if the block should be accepted
    task automatic start_block(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] exp, input bit accept);
        bus.start     = 1'b1;
        bus.plaintext = pt;
        bus.key       = k;
        if (accept) sb.push_back(exp);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_low);
        n = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            if (bus.busy !== 1'b1) busy_low++;
            tick();
            n++;
        end
    endtask

    function automatic logic [127:0] pop_expected();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.plaintext = '0;
        bus.key = '0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passes++;
        checks++; if (bus.ciphertext !== 128'h0) $display("FAIL reset_ct: got %h want 0", bus.ciphertext); else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips_b();
        int n, bl;
        logic [127:0] exp;
        start_block(PT_B, K_B, CT_B, 1'b1);
        checks++; if (bus.busy !== 1'b1) $display("FAIL b_busy_after_start: got %b want 1", bus.busy); else passes++;
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 10) $display("FAIL b_latency: got %0d cycles want 10", n); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL b_ct: got %h want %h", bus.ciphertext, exp); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL b_busy_in_done: got %b want 0", bus.busy); else passes++;
        checks++; if (bl !== 0) $display("FAIL b_busy_gap: busy low %0d cycles want 0", bl); else passes++;
        tick();
        checks++; if (bus.done !== 1'b0) $display("FAIL b_done_width: got %b want 0", bus.done); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL b_ct_hold: got %h want %h", bus.ciphertext, exp); else passes++;
    endtask

    task automatic test_fips_c1();
        int n, bl;
        logic [127:0] exp;
        start_block(PT_C, K_C, CT_C, 1'b1);
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 10) $display("FAIL c1_latency: got %0d cycles want 10", n); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL c1_ct: got %h want %h", bus.ciphertext, exp); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n, bl;
        logic [127:0] exp;
        start_block(PT_B, K_B, CT_B, 1'b1);
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (bus.ciphertext !== exp) $display("FAIL b2b_ct1: got %h want %h", bus.ciphertext, exp); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_done1: got %b want 0", bus.busy); else passes++;
        start_block(PT_C, K_C, CT_C, 1'b1);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL b2b_restart: got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); else passes++;
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 10) $display("FAIL b2b_spacing: got %0d cycles want 10", n); else passes++;
        checks++; if (bl !== 0) $display("FAIL b2b_busy_gap: busy low %0d cycles want 0", bl); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL b2b_ct2: got %h want %h", bus.ciphertext, exp); else passes++;
        tick();
    endtask

    task automatic test_ignored_start();
        int n, bl, extra;
        logic [127:0] exp;
        start_block(PT_B, K_B, CT_B, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            bus.start     = (i == 3 || i == 7);
            bus.plaintext = PT_C;
            bus.key       = K_C;
            tick();
        end
        bus.start = 1'b0;
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 1) $display("FAIL ign_latency: got %0d extra cycles want 1", n); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL ign_ct: got %h want %h", bus.ciphertext, exp); else passes++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) $display("FAIL ign_extra_activity: got %0d cycles want 0", extra); else passes++;
        checks++; if (sb.size() !== 0) $display("FAIL ign_queue: got %0d pending want 0", sb.size()); else passes++;
    endtask

    task automatic test_reset_abort();
        int n, bl;
        logic [127:0] exp;
        start_block(PT_C, K_C, CT_C, 1'b1);
        repeat (4) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL abort_done: got %b want 0", bus.done); else passes++;
        checks++; if (bus.ciphertext !== 128'h0) $display("FAIL abort_ct: got %h want 0", bus.ciphertext); else passes++;
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        start_block(PT_B, K_B, CT_B, 1'b1);
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 10) $display("FAIL abort_rerun_latency: got %0d cycles want 10", n); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL abort_rerun_ct: got %h want %h", bus.ciphertext, exp); else passes++;
        tick();
    endtask

    task automatic test_input_churn();
        int n, bl;
        logic [127:0] exp;
        start_block(PT_C, K_C, CT_C, 1'b1);
        for (int i = 0; i < 9; i++) begin
            bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            bus.key       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        wait_done(n, bl);
        exp = pop_expected();
        checks++; if (n !== 1) $display("FAIL churn_latency: got %0d extra cycles want 1", n); else passes++;
        checks++; if (bus.ciphertext !== exp) $display("FAIL churn_ct: got %h want %h", bus.ciphertext, exp); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
        test_input_churn();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
